// File: rtl/conv_pool_mc.sv
// conv_pool_mc: streams 4x4 pixel blocks, applies NUM_CH signed 3x3 kernels, and 2x2 max/avg pools
// each channel to one byte per block. Results leave through a credit-limited show-ahead FIFO.
module conv_pool_mc #(
  parameter int NUM_CH     = 3,
  parameter int NUM_BLKS   = 65536,
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAC_BITS  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pool_mode,
  input  logic [1:0]             shift,
  input  logic [NUM_CH*72-1:0]   kernels,
  input  logic [127:0]           image_4x4,
  input  logic                   out_ready,
  output logic                   input_re,
  output logic [ADDR_W-1:0]      input_addr,
  output logic                   output_we,
  output logic [ADDR_W-1:0]      output_addr,
  output logic [NUM_CH*8-1:0]    y,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int YW = NUM_CH * 8;
  localparam int EW = ADDR_W + YW;
  localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLKS - 1);
  localparam logic [CW:0]       DEPTH_C  = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;

  function automatic logic [7:0] chan_result(input logic [127:0] img, input logic [71:0] kern,
                                             input logic [1:0] sh, input logic avg);
    logic signed [19:0] acc, pix, cof, v;
    logic [7:0]  cl, mx;
    logic [9:0]  sum;
    logic [4:0]  sa;
    sa  = 5'(FRAC_BITS) + {3'd0, sh};
    sum = 10'd0;
    mx  = 8'd0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        acc = 20'sd0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            pix = $signed({12'd0, img[((i + dr) * 4 + (j + dc)) * 8 +: 8]});
            cof = $signed({{12{kern[(i * 3 + j) * 8 + 7]}}, kern[(i * 3 + j) * 8 +: 8]});
            acc = acc + pix * cof;
          end
        end
        v = acc >>> sa;
        if (v < 20'sd0) cl = 8'd0;
        else if (v > 20'sd255) cl = 8'd255;
        else cl = v[7:0];
        sum = sum + {2'd0, cl};
        if (cl > mx) mx = cl;
        else mx = mx;
      end
    end
    return avg ? sum[9:2] : mx;
  endfunction

  state_e               state_q, state_d;
  logic                 busy_s, done_s, issue_s, start_s, push_s, pop_s, finish_s;
  logic [CW:0]          used_s;
  logic [ADDR_W-1:0]    blk_cnt_q, input_addr_q, wr_addr_q, last_addr_q;
  logic                 input_re_q, mode_q, cap_vld_q, comp_vld_q;
  logic [1:0]           shift_q;
  logic [NUM_CH*72-1:0] kern_q;
  logic [MEM_LAT-1:0]   vld_sr_q, vld_sr_d;
  logic [127:0]         cap_q;
  logic [YW-1:0]        comp_q, comp_d, last_y_q;
  logic [EW-1:0]        fifo_mem_q [FIFO_DEPTH];
  logic [EW-1:0]        head_s;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        occ_q, inflight_q;

  // Credits count both queued results and requests whose data is still on its way.
  assign used_s   = {1'b0, occ_q} + {1'b0, inflight_q};
  assign finish_s = (occ_q == CW'(0)) && (inflight_q == CW'(0));
  assign push_s   = comp_vld_q;
  assign pop_s    = (occ_q != CW'(0)) && out_ready;
  assign head_s   = fifo_mem_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN; else state_d = ST_IDLE;
      ST_RUN:   if (issue_s && (blk_cnt_q == LAST_BLK)) state_d = ST_DRAIN; else state_d = ST_RUN;
      ST_DRAIN: if (finish_s) state_d = ST_IDLE; else state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; busy drops in the same cycle done pulses
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    issue_s = 1'b0;
    start_s = 1'b0;
    case (state_q)
      ST_IDLE:  start_s = start;
      ST_RUN: begin
        busy_s  = 1'b1;
        issue_s = (used_s < DEPTH_C);
      end
      ST_DRAIN: begin
        busy_s = ~finish_s;
        done_s = finish_s;
      end
      default: busy_s = 1'b0;
    endcase
  end

  // Frame configuration latch and read-request generation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kern_q       <= '0;
      shift_q      <= 2'd0;
      mode_q       <= 1'b0;
      blk_cnt_q    <= '0;
      wr_addr_q    <= '0;
      input_re_q   <= 1'b0;
      input_addr_q <= '0;
    end else begin
      input_re_q <= issue_s;
      if (start_s) begin
        kern_q    <= kernels;
        shift_q   <= shift;
        mode_q    <= pool_mode;
        blk_cnt_q <= '0;
        wr_addr_q <= '0;
      end
      if (issue_s) begin
        input_addr_q <= blk_cnt_q;
        if (blk_cnt_q != LAST_BLK) blk_cnt_q <= blk_cnt_q + ADDR_W'(1);
      end
      if (push_s) wr_addr_q <= wr_addr_q + ADDR_W'(1);
    end
  end

  // Delay line marking the cycle memory data is valid
  always_comb begin
    vld_sr_d    = vld_sr_q;
    vld_sr_d[0] = input_re_q;
    for (int i = 1; i < MEM_LAT; i++) vld_sr_d[i] = vld_sr_q[i - 1];
  end

  // Per-channel convolution and pooling on the captured block
  always_comb begin
    comp_d = '0;
    for (int k = 0; k < NUM_CH; k++)
      comp_d[k * 8 +: 8] = chan_result(cap_q, kern_q[k * 72 +: 72], shift_q, mode_q);
  end

  // Capture and compute pipeline stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr_q   <= '0;
      cap_vld_q  <= 1'b0;
      cap_q      <= '0;
      comp_vld_q <= 1'b0;
      comp_q     <= '0;
    end else begin
      vld_sr_q   <= vld_sr_d;
      cap_vld_q  <= vld_sr_q[MEM_LAT - 1];
      comp_vld_q <= cap_vld_q;
      if (vld_sr_q[MEM_LAT - 1]) cap_q <= image_4x4;
      if (cap_vld_q) comp_q <= comp_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_q[wr_ptr_q] <= {wr_addr_q, comp_q};
  end

  // FIFO pointers, occupancy, in-flight tracking and held output values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      inflight_q  <= '0;
      last_y_q    <= '0;
      last_addr_q <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        last_y_q    <= head_s[YW-1:0];
        last_addr_q <= head_s[EW-1:YW];
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
      case ({issue_s, push_s})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign input_re    = input_re_q;
  assign input_addr  = input_addr_q;
  assign output_we   = pop_s;
  assign y           = pop_s ? head_s[YW-1:0] : last_y_q;
  assign output_addr = pop_s ? head_s[EW-1:YW] : last_addr_q;
  assign busy        = busy_s;
  assign done        = done_s;

endmodule

// File: doc/conv_pool_mc.md
Name: conv_pool_mc

Overview:
Parametrised multi-channel successor to the single-pass 3-channel convolution + 2×2 pooling engine. It streams NUM_BLKS 4×4 image blocks from input memory and applies NUM_CH signed 3×3 kernels to each block. Each channel produces one pooled 8-bit value per block, and results are written to output memory. New relative to the previous generation: start/busy/done control, latched configuration, selectable max/average pooling, parametric memory read latency, and output backpressure via a credit-limited result FIFO.

Parameters:
NUM_CH, 3, number of kernels/output channels (1..8)
NUM_BLKS, 65536, blocks per frame (1..2^ADDR_W)
ADDR_W, 16, address width for input and output memory
MEM_LAT, 2, input memory read latency in cycles (1..4)
FIFO_DEPTH, 8, result FIFO entries, power of two, at least MEM_LAT+3
FRAC_BITS, 3, fractional bits of kernel coefficients

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse that begins a frame
pool_mode  input  1  0 = max pool, 1 = average pool
shift  input  2  extra right shift of 0..3
kernels  input  NUM_CH*72  channel k at [k*72 +: 72]; coeff (r,c) at [(r*3+c)*8 +: 8], signed
image_4x4  input  128  pixel (r,c) at [(r*4+c)*8 +: 8], unsigned
out_ready  input  1  output memory can accept a write this cycle
input_re  output  1  input memory read request
input_addr  output  ADDR_W  block index being read
output_we  output  1  write strobe, common to all channels
output_addr  output  ADDR_W  block index of y
y  output  NUM_CH*8  channel k result at [k*8 +: 8]
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last write

Behaviour:
- Reset (rst low, async) clears every output to 0, the FSM to IDLE, all counters and the FIFO, and every pipeline valid bit. Reset mid-frame discards in-flight data. Data returned by memory after reset is ignored.
- FSM states and transitions:
  - IDLE: on start, latch kernels, shift and pool_mode, then go to RUN. busy rises the cycle after start.
  - RUN: issue reads. After the request for block NUM_BLKS-1, go to DRAIN.
  - DRAIN: wait until the last result is written. Then pulse done for one cycle, drop busy in that same cycle, and return to IDLE.
- start while busy is ignored. Changes to config inputs during a frame have no effect.
- Request rule: in RUN, input_re=1 and input_addr=blk_cnt in a cycle where credits > 0. Credits = FIFO_DEPTH minus (FIFO occupancy + requests in flight). Back-to-back requests are allowed, one per cycle.
- image_4x4 is valid exactly MEM_LAT cycles after its input_re cycle. Pipeline:
  - capture register at +MEM_LAT+1;
  - compute register at +MEM_LAT+2, pushed into the FIFO;
  - FIFO is show-ahead.
  - With out_ready held high, output_we is asserted at cycle +MEM_LAT+3 after input_re.
- Output: output_we = FIFO non-empty AND out_ready. y and output_addr come from the FIFO head. When output_we=0, y and output_addr hold their last values. Results emerge in address order with no loss or duplication.
- FIFO is never pushed while full; the credit rule guarantees this. Push and pop in the same cycle keeps occupancy unchanged.
- Arithmetic, per channel, for each 2×2 output position (dr,dc):
  - acc = Σ pixel(i+dr, j+dc) × coeff(i,j), with the pixel zero-extended and the product signed.
  - acc is a 20-bit signed value, with no overflow possible.
  - v = acc >>> (FRAC_BITS+shift), arithmetic shift (floor).
  - Clamp v to 0..255.
- Pooling: max of the four clamped values, or the floor of their 10-bit sum >> 2 (average).
- Boundary cases:
  - NUM_BLKS=1: one request, then DRAIN.
  - blk_cnt does not wrap.
  - done fires exactly once per frame.

Test Plan:
1. Identity kernel (coeff(1,1)=8, others 0), shift 0, max pool, NUM_CH=1, pixel(r,c)=16r+c -> y=34 at each address 0..NUM_BLKS-1. First output_we at input_re+MEM_LAT+3.
2. Same stimulus with pool_mode=1 -> y=25, i.e. (17+18+33+34)>>2. Identity kernel, shift=2, all pixels 200 -> y=50.
3. Saturation with NUM_CH=3:
   - channel 0 all coeffs 127, all pixels 255 -> 255;
   - channel 1 all coeffs -128 -> 0;
   - channel 2 zero kernel -> 0.
4. Backpressure: out_ready low for 30 cycles mid-frame -> input_re stops after FIFO_DEPTH outstanding. Zero writes while stalled. After release, addresses continue contiguously and no block is missing.
5. Control: start pulsed again while busy, and kernels changed mid-frame -> both ignored. done pulses once, one cycle after the write of address NUM_BLKS-1, with busy falling in that cycle. NUM_BLKS=1 frame completes.
6. Reset mid-frame (rst low for 1 cycle during RUN) -> all outputs 0 immediately, returned data ignored. A new start runs a clean frame from address 0.
